// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers,
// with bounded burst locking and a completion watchdog.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_lock,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int WW  = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  // Registered outputs lag one cycle, so the error is launched one count early.
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [IDW-1:0]   ptr_r, ptr_s;
  logic [BW-1:0]    burst_r, burst_s;
  logic [WW-1:0]    wd_r, wd_s;
  logic [IDW-1:0]   win_s;
  logic [N_REQ-1:0] ready_s;
  logic             start_s;
  logic [7:0]       data_s;
  logic             gvalid_s;
  logic [IDW-1:0]   gid_s;
  logic             terr_s;

  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [IDW-1:0]   base);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    win = base;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(base) + k) % N_REQ);
      if (valid[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return IDW'((int'(id) + 1) % N_REQ);
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*N_REQ-1:0] data,
                                         input logic [IDW-1:0]     id);
    logic [8*N_REQ-1:0] shifted;
    shifted = data >> {id, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Next-state and next-output decode for the grant FSM.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    burst_s  = burst_r;
    wd_s     = wd_r;
    ready_s  = '0;
    start_s  = 1'b0;
    data_s   = tx_data;
    gvalid_s = grant_valid;
    gid_s    = grant_id;
    terr_s   = 1'b0;
    win_s    = rr_pick(req_valid, ptr_r);
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          data_s   = byte_of(req_data, win_s);
          gid_s    = win_s;
          gvalid_s = 1'b1;
          ready_s  = onehot(win_s);
          state_s  = LOAD;
        end else begin
          state_s  = IDLE;
        end
      end
      // LOAD already samples tx_busy so an idle transmitter starts two cycles after the request.
      LOAD, START: begin
        if (!tx_busy) begin
          start_s = 1'b1;
          wd_s    = '0;
          state_s = WAIT;
        end else begin
          state_s = START;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (req_lock[grant_id] && req_valid[grant_id] && (burst_r < BURST_LAST)) begin
            data_s  = byte_of(req_data, grant_id);
            ready_s = onehot(grant_id);
            burst_s = burst_r + BW'(1);
            state_s = LOAD;
          end else begin
            gvalid_s = 1'b0;
            ptr_s    = next_id(grant_id);
            burst_s  = '0;
            state_s  = IDLE;
          end
        end else if (wd_r == WD_LAST) begin
          terr_s   = 1'b1;
          gvalid_s = 1'b0;
          ptr_s    = next_id(grant_id);
          burst_s  = '0;
          state_s  = IDLE;
        end else begin
          wd_s = wd_r + WW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      burst_r     <= '0;
      wd_r        <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      burst_r     <= burst_s;
      wd_r        <= wd_s;
      req_ready   <= ready_s;
      tx_start    <= start_s;
      tx_data     <= data_s;
      grant_valid <= gvalid_s;
      grant_id    <= gid_s;
      timeout_err <= terr_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus
// hand-written sequences for arbitration order, bursts, timeout and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] lk;
    logic       b;
    logic       d;
    logic [3:0] rdy;
    logic       st;
    logic [7:0] dat;
    logic       gv;
    logic [1:0] gid;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic [3:0] lk, input logic b, input logic d,
                     input logic [3:0] rdy, input logic st, input logic [7:0] dat,
                     input logic gv, input logic [1:0] gid, input logic [1:0] ptr);
    vec_t e;
    e.v = v; e.lk = lk; e.b = b; e.d = d;
    e.rdy = rdy; e.st = st; e.dat = dat; e.gv = gv; e.gid = gid; e.ptr = ptr;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_err, dut.ptr_r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a req_ready pulse is seen; tx_done is a one-cycle pulse.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      step();
      tx_done = 1'b0;
      cyc++;
    end while (req_ready == 4'b0000 && cyc < 20);
    total++;
    if (req_ready == 4'b0000) begin
      bad++;
      $display("FAIL ready_wait: no req_ready within %0d cycles", cyc);
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!tx_start && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!tx_start) begin
      bad++;
      $display("FAIL start_wait: no tx_start within %0d cycles", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int         cyc;
    int         n;
    logic [3:0] oh;
    logic [7:0] exp_dat;
    int         exp_cyc;

    reset     = 1'b1;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    req_data  = {8'h3C, 8'hA5, 8'h21, 8'h10};
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (3) step();
    chk("reset_state", 32'(outs()), 32'd0);
    reset = 1'b0;

    // Single requester, busy transmitter, ignored tx_done outside WAIT.
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 8'hA5, 1'b1, 2'd2, 2'd0);
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd2, 2'd0);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd2, 2'd0);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd2, 2'd3);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd2, 2'd3);
    add(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 8'h21, 1'b1, 2'd1, 2'd3);
    for (int k = 0; k < 10; k++) begin
      add((k == 0) ? 4'b0010 : 4'b0000, 4'b0000, 1'b1, (k == 3) ? 1'b1 : 1'b0,
          4'b0000, 1'b0, 8'h21, 1'b1, 2'd1, 2'd3);
    end
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h21, 1'b1, 2'd1, 2'd3);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h21, 1'b0, 2'd1, 2'd2);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h21, 1'b0, 2'd1, 2'd2);

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v;
      req_lock  = tbl[i].lk;
      tx_busy   = tbl[i].b;
      tx_done   = tbl[i].d;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({tbl[i].rdy, tbl[i].st, tbl[i].dat, tbl[i].gv, tbl[i].gid, 1'b0, tbl[i].ptr}));
    end
    req_valid = 4'b0000;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;

    // Simultaneous requests from a fresh pointer: strict rotation 0,1,2,3,...
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ready(cyc);
      oh = 4'b0001 << (i % 4);
      exp_dat = (i % 4 == 0) ? 8'h10 : (i % 4 == 1) ? 8'h21 : (i % 4 == 2) ? 8'hA5 : 8'h3C;
      chk($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(oh));
      chk($sformatf("rr%0d_data", i), 32'(tx_data), 32'(exp_dat));
      chk($sformatf("rr%0d_lat", i), 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
      step();
      wait_start();
      chk($sformatf("rr%0d_start_data", i), 32'(tx_data), 32'(exp_dat));
      tx_done = 1'b1;
    end
    req_valid = 4'b0000;
    step();
    tx_done = 1'b0;
    chk("rr_release", 32'({grant_valid, dut.ptr_r}), 32'({1'b0, 2'd0}));

    // Burst lock: requester 1 sends exactly four bytes, then requester 3 gets a turn.
    req_data[15:8] = 8'h50;
    req_valid = 4'b1010;
    req_lock  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      wait_ready(cyc);
      oh      = (k < 4) ? 4'b0010 : 4'b1000;
      exp_dat = (k < 4) ? 8'(8'h50 + k) : 8'h3C;
      exp_cyc = (k == 4) ? 2 : 1;
      chk($sformatf("burst%0d_ready", k), 32'(req_ready), 32'(oh));
      chk($sformatf("burst%0d_data", k), 32'(tx_data), 32'(exp_dat));
      chk($sformatf("burst%0d_lat", k), 32'(cyc), 32'(exp_cyc));
      step();
      if (k < 4) begin
        req_data[15:8] = 8'(8'h51 + k);
      end else begin
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
      end
      wait_start();
      tx_done = 1'b1;
    end
    step();
    tx_done = 1'b0;
    chk("burst_release", 32'({grant_valid, dut.ptr_r}), 32'({1'b0, 2'd0}));

    // Watchdog: no tx_done ever arrives.
    req_valid = 4'b0001;
    wait_ready(cyc);
    chk("to_ready", 32'(req_ready), 32'(4'b0001));
    step();
    req_valid = 4'b0000;
    wait_start();
    n = 1;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    chk("to_cycle", 32'(n), 32'd16);
    chk("to_release", 32'({grant_valid, dut.ptr_r}), 32'({1'b0, 2'd1}));
    step();
    chk("to_width", 32'(timeout_err), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("stray_done", 32'(outs()), 32'({4'b0000, 1'b0, 8'h10, 1'b0, 2'd0, 1'b0, 2'd1}));
    step();
    chk("stray_done2", 32'(outs()), 32'({4'b0000, 1'b0, 8'h10, 1'b0, 2'd0, 1'b0, 2'd1}));

    // Reset in the middle of a locked burst.
    req_data[15:8] = 8'h60;
    req_valid = 4'b0011;
    req_lock  = 4'b0010;
    wait_ready(cyc);
    chk("mid_ready1", 32'(req_ready), 32'(4'b0010));
    step();
    wait_start();
    tx_done = 1'b1;
    wait_ready(cyc);
    chk("mid_ready2", 32'(req_ready), 32'(4'b0010));
    chk("mid_lat", 32'(cyc), 32'd1);
    step();
    wait_start();
    step();
    step();
    chk("mid_owned", 32'({grant_valid, grant_id}), 32'({1'b1, 2'd1}));
    reset = 1'b1;
    #1;
    chk("reset_async", 32'(outs()), 32'd0);
    step();
    chk("reset_hold", 32'(outs()), 32'd0);
    reset = 1'b0;
    wait_ready(cyc);
    chk("post_reset_lat", 32'(cyc), 32'd1);
    chk("post_reset_win", 32'({req_ready, grant_id, tx_data}), 32'({4'b0001, 2'd0, 8'h10}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
